uart_mmio_ctrl: RTL and testbench
=================================

// Module: uart_mmio_ctrl
// PURPOSE
// - Memory-mapped controller sequencing the UART sender/receiver pair for the MIPS core.
// - CPU stores bytes to TXD; block launches the sender with a one-cycle tx_en and tracks completion.
// - Receiver-completed bytes are captured into RXD with valid/overrun status; an irq output is raised.
// - Sits between the CPU data-memory bus decode and the UART sender/receiver; all logic in the sysclk domain.
// PARAMETERS
// - BASE_ADDR      32'h4000_0018  TXD address; RXD = BASE+4, CON = BASE+8
// - LAUNCH_TIMEOUT 16'd4096       sysclk cycles to wait for the sender busy ack before abort
// - FIFO_DEPTH     4              TX FIFO entries (power of 2), used only with UART_TX_FIFO_EN
// PORTS
// - sysclk     in   1   system clock
// - reset      in   1   asynchronous, active-low reset
// - addr       in   32  CPU data address
// - wdata      in   32  CPU store data
// - mem_write  in   1   store strobe, one cycle per store
// - mem_read   in   1   load strobe
// - rdata      out  32  read data, combinational from addr; 0 when addr not in block
// - tx_data    out  8   byte to sender, stable from launch until sender idle again
// - tx_en      out  1   launch pulse, 1 sysclk cycle
// - tx_status  in   1   sender idle (1) / busy (0), baud domain -> 2-FF synchronised
// - rx_data    in   8   receiver byte, stable while rx_status high
// - rx_status  in   1   receiver byte-ready level, sample domain -> 2-FF synchronised
// - irq        out  1   (tx_done & CON[0]) | (rx_valid & CON[1])
// BEHAVIOUR
// - Reset: rdata/tx_en/irq/tx_data = 0; CON = 0; FSM = IDLE; TX holding/FIFO empty; syncs cleared.
// - Registers: TXD W (bits[7:0]); RXD R (bits[7:0], zero-extended); CON R/W:
//   [0] tx_irq_en RW, [1] rx_irq_en RW, [2] tx_done W1C, [3] rx_valid RO,
//   [4] tx_busy RO, [5] rx_overrun W1C, [6] tx_drop W1C, [7] tx_timeout W1C; [31:8] read 0.
// - TX FSM: IDLE -> LAUNCH when holding reg full: tx_data<=byte, tx_en=1 for exactly first LAUNCH cycle.
//   LAUNCH -> BUSY when synced tx_status==0; LAUNCH -> IDLE after LAUNCH_TIMEOUT cycles, set tx_timeout, drop byte.
//   BUSY -> IDLE when synced tx_status==1; set tx_done, free holding reg. tx_busy = (state!=IDLE)|holding full.
// - TXD store when holding full (FIFO full): ignored, tx_drop set. Store in same cycle slot frees: accepted.
// - RX: rising edge of synced rx_status captures rx_data into RXD next cycle, rx_valid<=1;
//   if rx_valid already 1, overwrite and set rx_overrun.
// - Load of RXD (mem_read & addr==RXD) clears rx_valid at the clock edge; same-cycle new capture wins
//   (rx_valid stays 1, rx_overrun not set).
// - CON write with W1C bit and same-cycle set event: set wins.
// - Reset mid-frame: FSM returns to IDLE, tx_en low; the in-flight sender frame is not aborted.
// - Latency: store to tx_en = 1 cycle (IDLE); rx_status edge at pin to rx_valid = 3 cycles.
// CONFIGURATION
// - UART_TX_FIFO_EN defined: TXD feeds FIFO_DEPTH-entry FIFO, FSM pops head on IDLE; pointers wrap
//   mod FIFO_DEPTH with extra wrap bit for full/empty; tx_drop only when FIFO full.
// - Undefined: single-entry holding register; FIFO_DEPTH ignored.
// STRUCTURE
// - Shared defs header uart_ctrl_defs: register offsets, CON bit indices, FSM state encodings.
// - Sub-module uart_sync_2ff (async active-low reset, 1-bit) instanced for tx_status and rx_status.
// TESTING
// - Store 0x55 to TXD, model sender drops tx_status 3 cycles later, rises 200 later -> tx_en one
//   cycle, tx_data=0x55, tx_done=1, tx_busy=0 after release.
// - Two back-to-back stores 0x11,0x22 without FIFO -> 0x22 ignored, CON[6]=1; with
//   UART_TX_FIFO_EN -> both sent in order, no drop.
// - tx_status held high after launch -> after LAUNCH_TIMEOUT cycles CON[7]=1, FSM IDLE, tx_busy=0.
// - Two rx_status pulses with 0xA5 then 0x3C, no RXD load -> RXD=0x3C, rx_valid=1, rx_overrun=1.
// - RXD load coincident with new capture 0x7E -> rdata old byte, rx_valid stays 1, no overrun.
// - CON=0x3, rx byte arrives -> irq=1; RXD load -> irq=0; reset asserted mid-BUSY -> all outputs 0.

Source files
------------

// File: rtl/uart_ctrl_defs.sv
// Shared definitions for the UART MMIO controller: register offsets, CON bit
// positions and the TX sequencer state encoding.
package uart_ctrl_defs;

    localparam logic [31:0] OFF_TXD = 32'h0;
    localparam logic [31:0] OFF_RXD = 32'h4;
    localparam logic [31:0] OFF_CON = 32'h8;

    localparam int CON_TX_IRQ_EN  = 0;
    localparam int CON_RX_IRQ_EN  = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_VALID   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_RX_OVERRUN = 5;
    localparam int CON_TX_DROP    = 6;
    localparam int CON_TX_TIMEOUT = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single level crossing into the sysclk domain.
module uart_sync_2ff (
    input  logic sysclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops are written with <= so every register samples the pre-edge value.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TXD/RXD/CON registers, TX launch sequencer, RX capture.
// Define UART_TX_FIFO_EN to replace the single TX holding register with a FIFO_DEPTH-entry FIFO.
module uart_mmio_ctrl
    import uart_ctrl_defs::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h4000_0018,
    parameter logic [15:0] LAUNCH_TIMEOUT = 16'd4096,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_status,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic        irq
);

    localparam logic [31:0] TXD_ADDR = BASE_ADDR + OFF_TXD;
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + OFF_RXD;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + OFF_CON;

    logic tx_idle_s, rx_rdy_s, rx_rdy_d;

    uart_sync_2ff u_sync_tx (.sysclk(sysclk), .reset(reset), .d(tx_status), .q(tx_idle_s));
    uart_sync_2ff u_sync_rx (.sysclk(sysclk), .reset(reset), .d(rx_status), .q(rx_rdy_s));

    logic wr_txd, wr_con, rd_rxd;
    assign wr_txd = mem_write && (addr == TXD_ADDR);
    assign wr_con = mem_write && (addr == CON_ADDR);
    assign rd_rxd = mem_read  && (addr == RXD_ADDR);

    tx_state_e   state;
    logic [15:0] launch_cnt;
    logic        tx_irq_en, rx_irq_en, tx_done, rx_valid, rx_overrun, tx_drop, tx_timeout;
    logic [7:0]  rxd;

    logic done_evt, timeout_evt;
    assign done_evt    = (state == ST_BUSY) && tx_idle_s;
    assign timeout_evt = (state == ST_LAUNCH) && tx_idle_s && (launch_cnt == LAUNCH_TIMEOUT - 16'd1);

    // Pending-byte source seen by the sequencer; store_ok is an accepted TXD write.
    logic       pend_valid, store_ok, queue_busy;
    logic [7:0] pend_byte;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, pop, push;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign store_ok   = wr_txd && (!fifo_full || pop);
    // An empty FIFO in IDLE launches the store directly instead of queueing it.
    assign push       = store_ok && !((state == ST_IDLE) && fifo_empty);
    assign pend_valid = !fifo_empty;
    assign pend_byte  = fifo_mem[rd_ptr[AW-1:0]];
    assign queue_busy = !fifo_empty;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge sysclk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= wdata[7:0];
    end
`else
    logic       hold_full;
    logic [7:0] hold_byte;

    // The holding register stays full for the whole frame and frees on done or timeout.
    assign store_ok   = wr_txd && (!hold_full || done_evt || timeout_evt);
    assign pend_valid = hold_full;
    assign pend_byte  = hold_byte;
    assign queue_busy = hold_full;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            hold_full <= 1'b0;
            hold_byte <= 8'h00;
        end else if (store_ok) begin
            hold_full <= 1'b1;
            hold_byte <= wdata[7:0];
        end else if (done_evt || timeout_evt) begin
            hold_full <= 1'b0;
        end
    end
`endif

    logic drop_evt, start_evt;
    assign drop_evt  = wr_txd && !store_ok;
    assign start_evt = (state == ST_IDLE) && (pend_valid || store_ok);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tx_en      <= 1'b0;
            tx_data    <= 8'h00;
            launch_cnt <= 16'd0;
        end else begin
            tx_en <= 1'b0;
            case (state)
                ST_IDLE: if (start_evt) begin
                    state      <= ST_LAUNCH;
                    tx_en      <= 1'b1;
                    tx_data    <= pend_valid ? pend_byte : wdata[7:0];
                    launch_cnt <= 16'd0;
                end
                ST_LAUNCH: begin
                    if (!tx_idle_s)       state <= ST_BUSY;
                    else if (timeout_evt) state <= ST_IDLE;
                    else                  launch_cnt <= launch_cnt + 16'd1;
                end
                ST_BUSY: if (tx_idle_s) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic rx_cap, overrun_evt;
    assign rx_cap      = rx_rdy_s && !rx_rdy_d;
    assign overrun_evt = rx_cap && rx_valid && !rd_rxd;

    // Status flags: a same-cycle set event beats a W1C clear.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_irq_en  <= 1'b0;
            rx_irq_en  <= 1'b0;
            tx_done    <= 1'b0;
            tx_drop    <= 1'b0;
            tx_timeout <= 1'b0;
            rx_overrun <= 1'b0;
            rx_valid   <= 1'b0;
            rx_rdy_d   <= 1'b0;
            rxd        <= 8'h00;
        end else begin
            if (wr_con) begin
                tx_irq_en <= wdata[CON_TX_IRQ_EN];
                rx_irq_en <= wdata[CON_RX_IRQ_EN];
            end
            tx_done    <= done_evt    || (tx_done    && !(wr_con && wdata[CON_TX_DONE]));
            tx_drop    <= drop_evt    || (tx_drop    && !(wr_con && wdata[CON_TX_DROP]));
            tx_timeout <= timeout_evt || (tx_timeout && !(wr_con && wdata[CON_TX_TIMEOUT]));
            rx_overrun <= overrun_evt || (rx_overrun && !(wr_con && wdata[CON_RX_OVERRUN]));
            rx_valid   <= rx_cap || (rx_valid && !rd_rxd);
            rx_rdy_d   <= rx_rdy_s;
            if (rx_cap) rxd <= rx_data;
        end
    end

    logic [7:0] con_rd;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        con_rd                 = 8'h00;
        con_rd[CON_TX_IRQ_EN]  = tx_irq_en;
        con_rd[CON_RX_IRQ_EN]  = rx_irq_en;
        con_rd[CON_TX_DONE]    = tx_done;
        con_rd[CON_RX_VALID]   = rx_valid;
        con_rd[CON_TX_BUSY]    = (state != ST_IDLE) || queue_busy;
        con_rd[CON_RX_OVERRUN] = rx_overrun;
        con_rd[CON_TX_DROP]    = tx_drop;
        con_rd[CON_TX_TIMEOUT] = tx_timeout;
    end

    always_comb begin
        rdata = 32'h0;
        if (addr == RXD_ADDR)      rdata[7:0] = rxd;
        else if (addr == CON_ADDR) rdata[7:0] = con_rd;
    end

    assign irq = (tx_done && tx_irq_en) || (rx_valid && rx_irq_en);

    logic unused_ok;
    assign unused_ok = ^{wdata[31:8], 32'(FIFO_DEPTH)};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl with a behavioural sender and RX register model.
module tb_uart_mmio_ctrl;

    localparam logic [31:0] A_TXD    = 32'h4000_0018;
    localparam logic [31:0] A_RXD    = 32'h4000_001C;
    localparam logic [31:0] A_CON    = 32'h4000_0020;
    localparam int          TIMEOUT  = 4096;
    localparam int          BUSY_LEN = 200;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic        mem_write = 1'b0;
    logic        mem_read  = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_status = 1'b1;
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_status = 1'b0;
    logic        irq;

    uart_mmio_ctrl dut (
        .sysclk(sysclk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_write(mem_write), .mem_read(mem_read), .rdata(rdata),
        .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status),
        .rx_data(rx_data), .rx_status(rx_status), .irq(irq)
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Sender model: logs every tx_en cycle, goes busy 3 cycles later, idle BUSY_LEN after that.
    logic [7:0] tx_log [$];
    bit         sender_on  = 1'b1;
    bit         snd_active = 1'b0;
    int         snd_cnt    = 0;

    always @(negedge sysclk) begin
        if (tx_en === 1'b1) begin
            tx_log.push_back(tx_data);
            snd_active = sender_on;
            snd_cnt    = 0;
        end else if (snd_active) begin
            snd_cnt++;
            if (snd_cnt == 3) tx_status = 1'b0;
            else if (snd_cnt == 3 + BUSY_LEN) begin
                tx_status  = 1'b1;
                snd_active = 1'b0;
            end
        end
    end

    // RX register model
    bit       m_valid = 1'b0;
    bit       m_ovr   = 1'b0;
    logic [7:0] m_byte = 8'h00;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge sysclk); addr = a; wdata = d; mem_write = 1'b1;
        @(negedge sysclk); mem_write = 1'b0; wdata = 32'h0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1 v = rdata;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge sysclk); addr = a; mem_read = 1'b1;
        #1 v = rdata;
        @(negedge sysclk); mem_read = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(negedge sysclk); rx_data = b; rx_status = 1'b1;
        repeat (5) @(negedge sysclk);
        rx_status = 1'b0;
        repeat (4) @(negedge sysclk);
        m_ovr   = m_ovr | m_valid;
        m_valid = 1'b1;
        m_byte  = b;
    endtask

    task automatic wait_con(input int bitn, input logic val, input int budget, output bit ok);
        logic [31:0] v;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge sysclk);
            peek(A_CON, v);
            if (v[bitn] === val) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b0;
        repeat (3) @(negedge sysclk);
        n_tests++; if (tx_en !== 1'b0 || irq !== 1'b0 || tx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: tx_en=%b irq=%b tx_data=%h, expected 0 0 00", tx_en, irq, tx_data);
        end
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        peek(A_CON, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_con: got %h expected 0", v); end
        peek(A_RXD, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_rxd: got %h expected 0", v); end
        peek(32'h0000_1000, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", v); end
    endtask

    task automatic test_tx_single;
        logic [31:0] v;
        logic [7:0]  b;
        bit          ok;
        int          n0;
        for (int k = 0; k < 3; k++) begin
            b  = (k == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            n0 = tx_log.size();
            bus_write(A_TXD, {24'($urandom), b});
            n_tests++; if (tx_en !== 1'b1 || tx_data !== b) begin
                n_fail++; $display("FAIL tx_launch: tx_en=%b tx_data=%h, expected 1 %h", tx_en, tx_data, b);
            end
            @(negedge sysclk);
            n_tests++; if (tx_en !== 1'b0) begin n_fail++; $display("FAIL tx_en_width: tx_en=%b expected 0", tx_en); end
            peek(A_CON, v);
            n_tests++; if (v[4] !== 1'b1) begin n_fail++; $display("FAIL tx_busy_set: got %b expected 1", v[4]); end
            wait_con(2, 1'b1, 400, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL tx_done_wait: tx_done never set, expected 1"); end
            peek(A_CON, v);
            n_tests++; if (v !== 32'h04) begin n_fail++; $display("FAIL tx_con_done: got %h expected 04", v); end
            n_tests++; if (tx_log.size() != n0 + 1 || tx_log[tx_log.size()-1] !== b) begin
                n_fail++; $display("FAIL tx_log: launches=%0d last=%h, expected %0d %h", tx_log.size() - n0, tx_log[tx_log.size()-1], 1, b);
            end
            bus_write(A_CON, 32'h1);
            n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tx_irq: got %b expected 1", irq); end
            bus_write(A_CON, 32'h5);
            peek(A_CON, v);
            n_tests++; if (irq !== 1'b0 || v !== 32'h01) begin
                n_fail++; $display("FAIL tx_w1c: irq=%b con=%h, expected 0 01", irq, v);
            end
            bus_write(A_CON, 32'h0);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        logic [7:0]  b1, b2;
        logic [7:0]  exp_con;
        bit          ok;
        int          n0;
        for (int k = 0; k < 2; k++) begin
            b1 = (k == 0) ? 8'h11 : 8'($urandom_range(0, 255));
            b2 = (k == 0) ? 8'h22 : ~b1;
            n0 = tx_log.size();
            @(negedge sysclk); addr = A_TXD; wdata = {24'h0, b1}; mem_write = 1'b1;
            @(negedge sysclk); wdata = {24'h0, b2};
            @(negedge sysclk); mem_write = 1'b0;
            wait_con(4, 1'b0, 1000, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_wait: tx_busy never cleared, expected 0"); end
            peek(A_CON, v);
`ifdef UART_TX_FIFO_EN
            exp_con = 8'h04;
            n_tests++; if (tx_log.size() != n0 + 2 || tx_log[n0] !== b1 || tx_log[n0+1] !== b2) begin
                n_fail++; $display("FAIL b2b_order: launches=%0d, expected 2 bytes %h %h", tx_log.size() - n0, b1, b2);
            end
`else
            exp_con = 8'h44;
            n_tests++; if (tx_log.size() != n0 + 1 || tx_log[n0] !== b1) begin
                n_fail++; $display("FAIL b2b_drop: launches=%0d, expected 1 byte %h", tx_log.size() - n0, b1);
            end
`endif
            n_tests++; if (v[7:0] !== exp_con) begin n_fail++; $display("FAIL b2b_con: got %h expected %h", v[7:0], exp_con); end
            bus_write(A_CON, 32'hC4);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] v;
        bit          ok;
        sender_on = 1'b0;
        bus_write(A_TXD, {24'h0, 8'($urandom_range(0, 255))});
        repeat (TIMEOUT - 8) @(negedge sysclk);
        peek(A_CON, v);
        n_tests++; if (v[7] !== 1'b0 || v[4] !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early: timeout=%b busy=%b, expected 0 1", v[7], v[4]);
        end
        wait_con(7, 1'b1, 30, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL timeout_wait: tx_timeout never set, expected 1"); end
        peek(A_CON, v);
        n_tests++; if (v !== 32'h80) begin n_fail++; $display("FAIL timeout_con: got %h expected 80", v); end
        bus_write(A_CON, 32'h80);
        peek(A_CON, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL timeout_clear: got %h expected 0", v); end
        sender_on = 1'b1;
    endtask

    task automatic test_rx;
        logic [31:0] v, c;
        // first arrival also checks the 3-cycle pin-to-valid latency
        @(negedge sysclk); rx_data = 8'hA5; rx_status = 1'b1;
        repeat (2) @(negedge sysclk);
        peek(A_CON, c);
        n_tests++; if (c[3] !== 1'b0) begin n_fail++; $display("FAIL rx_latency_early: valid=%b expected 0", c[3]); end
        @(negedge sysclk);
        peek(A_CON, c);
        n_tests++; if (c[3] !== 1'b1) begin n_fail++; $display("FAIL rx_latency: valid=%b expected 1", c[3]); end
        repeat (2) @(negedge sysclk);
        rx_status = 1'b0;
        repeat (4) @(negedge sysclk);
        m_ovr = m_ovr | m_valid; m_valid = 1'b1; m_byte = 8'hA5;
        rx_send(8'h3C);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus_read(A_RXD, v);
                    n_tests++; if (v !== {24'h0, m_byte}) begin
                        n_fail++; $display("FAIL rx_load: got %h expected %h", v, {24'h0, m_byte});
                    end
                    m_valid = 1'b0;
                end else begin
                    rx_send(8'($urandom_range(0, 255)));
                end
            end
            peek(A_RXD, v);
            peek(A_CON, c);
            n_tests++; if (v !== {24'h0, m_byte} || c[3] !== m_valid || c[5] !== m_ovr) begin
                n_fail++; $display("FAIL rx_state: rxd=%h valid=%b ovr=%b, expected %h %b %b", v[7:0], c[3], c[5], m_byte, m_valid, m_ovr);
            end
        end
        bus_read(A_RXD, v);
        m_valid = 1'b0;
        bus_write(A_CON, 32'h20);
        m_ovr = 1'b0;
    endtask

    task automatic test_rx_collision;
        logic [31:0] v, c;
        rx_send(8'($urandom_range(0, 255)));
        @(negedge sysclk); rx_data = 8'h7E; rx_status = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk); addr = A_RXD; mem_read = 1'b1;
        #1 v = rdata;
        n_tests++; if (v !== {24'h0, m_byte}) begin n_fail++; $display("FAIL coll_old_byte: got %h expected %h", v, {24'h0, m_byte}); end
        @(negedge sysclk); mem_read = 1'b0;
        m_byte = 8'h7E; m_valid = 1'b1;
        peek(A_RXD, v);
        peek(A_CON, c);
        n_tests++; if (v !== 32'h7E || c[3] !== 1'b1 || c[5] !== 1'b0) begin
            n_fail++; $display("FAIL coll_capture: rxd=%h valid=%b ovr=%b, expected 7e 1 0", v[7:0], c[3], c[5]);
        end
        repeat (2) @(negedge sysclk);
        rx_status = 1'b0;
        repeat (4) @(negedge sysclk);
        bus_read(A_RXD, v);
        m_valid = 1'b0;
    endtask

    task automatic test_irq_reset;
        logic [31:0] v;
        logic [7:0]  b;
        bus_write(A_CON, 32'h3);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b expected 0", irq); end
        rx_send(8'($urandom_range(0, 255)));
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx: got %b expected 1", irq); end
        bus_read(A_RXD, v);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_rx_load: got %b expected 0", irq); end
        rx_send(8'($urandom_range(0, 255)));
        b = 8'($urandom_range(1, 255));
        bus_write(A_TXD, {24'h0, b});
        repeat (30) @(negedge sysclk);
        peek(A_CON, v);
        n_tests++; if (v[4] !== 1'b1 || irq !== 1'b1 || tx_data !== b) begin
            n_fail++; $display("FAIL pre_reset: busy=%b irq=%b tx_data=%h, expected 1 1 %h", v[4], irq, tx_data, b);
        end
        reset = 1'b0;
        peek(A_CON, v);
        n_tests++; if (tx_en !== 1'b0 || irq !== 1'b0 || tx_data !== 8'h00 || v !== 32'h0) begin
            n_fail++; $display("FAIL mid_busy_reset: tx_en=%b irq=%b tx_data=%h con=%h, expected 0 0 00 0", tx_en, irq, tx_data, v);
        end
        @(negedge sysclk); reset = 1'b1;
        m_valid = 1'b0; m_ovr = 1'b0; m_byte = 8'h00;
        repeat (BUSY_LEN + 20) @(negedge sysclk);
        peek(A_CON, v);
        n_tests++; if (v !== 32'h0 || tx_status !== 1'b1) begin
            n_fail++; $display("FAIL post_reset: con=%h tx_status=%b, expected 0 1", v, tx_status);
        end
        peek(A_RXD, v);
        n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL post_reset_rxd: got %h expected 0", v); end
    endtask

    initial begin
        test_reset;
        test_tx_single;
        test_back_to_back;
        test_timeout;
        test_rx;
        test_rx_collision;
        test_irq_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
